// File: rtl/sparce_mem_arb_pkg.sv
// sparceMemPkg: shared types and defaults for the sparce memory arbiter.
//   BC / BADDR : default byte-lane count of the data word and lane-select width.
//   op_e       : access size carried on requests and on the memory strobes.
//   arb_state_e: request-handling FSM states of sparce_mem_arb.
//   op_bytes() : access size in bytes (0 for NOP).
package sparceMemPkg;

  localparam int BC    = 8;
  localparam int BADDR = 3;

  typedef enum logic [2:0] {
    NOP      = 3'd0,
    BYTE_OP  = 3'd1,
    HALF_OP  = 3'd2,
    WORD_OP  = 3'd3,
    DWORD_OP = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } arb_state_e;

  function automatic int op_bytes(input op_e op);
    case (op)
      BYTE_OP:  return 1;
      HALF_OP:  return 2;
      WORD_OP:  return 4;
      DWORD_OP: return 8;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/sparce_mem_arb_rr_arb.sv
// sparce_mem_rr_arb: 2-way round-robin grant.
//   clk, rst : clock, synchronous active-high reset (pointer -> requester 0).
//   valid    : request bits from the two requesters.
//   adv      : a grant was taken this cycle; pointer moves past the winner.
//   grant    : one-hot grant (zero when nothing is valid).
//   idx      : index of the granted requester.
module sparce_mem_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       adv,
  output logic [1:0] grant,
  output logic       idx
);

  logic ptr_q;

  // The pointer names the preferred requester; fall back to the other one.
  always_comb begin
    idx   = ptr_q;
    grant = 2'b00;
    if (!valid[ptr_q]) idx = ~ptr_q;
    if (|valid)        grant[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)      ptr_q <= 1'b0;
    else if (adv) ptr_q <= ~idx;
  end

endmodule

// File: rtl/sparce_mem_arb.sv
// sparce_mem_arb: two requesters share one single-ported memory, one
// transaction in flight at a time.
//   clk, rst                 : clock, synchronous active-high reset.
//   req_valid/req_ready      : per-requester request handshake (ready pulses
//                              for one cycle on acceptance, only in IDLE).
//   req_write/op/addr/wdata  : request payload, wdata lane-aligned.
//   rsp_valid/rsp_ready      : per-requester response handshake.
//   rsp_err/rsp_rdata        : response payload (rdata lanes outside the
//                              access zeroed, all zero for writes/errors).
//   mem_cs/we/re/waddr/raddr/wdata : one-cycle memory strobe.
//   mem_rdata                : memory read data, one cycle after the strobe.
module sparce_mem_arb
  import sparceMemPkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BC     = sparceMemPkg::BC,
  parameter int BADDR  = sparceMemPkg::BADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [1:0]               req_write,
  input  op_e  [1:0]               req_op,
  input  logic [1:0][ADDR_W-1:0]   req_addr,
  input  logic [1:0][BC-1:0][7:0]  req_wdata,
  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic                     rsp_err,
  output logic [BC-1:0][7:0]       rsp_rdata,
  output logic                     mem_cs,
  output op_e                      mem_we,
  output op_e                      mem_re,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [ADDR_W-1:0]        mem_raddr,
  output logic [BC-1:0][7:0]       mem_wdata,
  input  logic [BC-1:0][7:0]       mem_rdata
);

  arb_state_e state_q, state_d;

  logic       take;
  logic [1:0] gnt;
  logic       gnt_idx;

  // latched transaction
  logic               own_q;
  logic               wr_q;
  logic               err_q;
  op_e                op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BC-1:0][7:0] wdata_q;
  logic [BC-1:0][7:0] rdata_q;

  // granted request, before latching
  op_e               sel_op;
  logic [ADDR_W-1:0] sel_addr;
  int                sel_sz;
  int                sel_off;
  logic              sel_bad;

  // read lane window of the latched request
  int          rd_sz;
  int          rd_off;
  logic [BC-1:0] keep;

  // No acceptance is signalled while reset is held: the edge would discard it.
  assign take = (state_q == IDLE) && (|req_valid) && !rst;

  sparce_mem_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .adv   (take),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign req_ready = take ? gnt : 2'b00;

  // Legality is decided on the granted request so the first state after
  // IDLE already knows whether the memory is touched at all.
  always_comb begin
    sel_op   = req_op[gnt_idx];
    sel_addr = req_addr[gnt_idx];
    sel_sz   = op_bytes(sel_op);
    sel_off  = int'(sel_addr[BADDR-1:0]);
    sel_bad  = (sel_sz == 0) || (sel_sz > BC) || ((sel_off & (sel_sz - 1)) != 0);
  end

  always_comb begin
    rd_sz  = op_bytes(op_q);
    rd_off = int'(addr_q[BADDR-1:0]);
  end

  for (genvar k = 0; k < BC; k++) begin : g_lane
    assign keep[k] = (k >= rd_off) && (k < rd_off + rd_sz);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = sel_bad ? RESP : ISSUE;
      ISSUE:   state_d = wr_q ? RESP : WAIT_RD;
      WAIT_RD: state_d = RESP;
      RESP:    if (rsp_ready[own_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------ datapath regs
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (take) begin
      own_q   <= gnt_idx;
      wr_q    <= req_write[gnt_idx];
      err_q   <= sel_bad;
      op_q    <= sel_op;
      addr_q  <= sel_addr;
      wdata_q <= req_wdata[gnt_idx];
      rdata_q <= '0;
    end else if (state_q == WAIT_RD) begin
      for (int k = 0; k < BC; k++)
        rdata_q[k] <= keep[k] ? mem_rdata[k] : 8'h00;
    end
  end

  // ------------------------------------------------------------ outputs
  assign mem_cs    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE &&  wr_q) ? op_q : NOP;
  assign mem_re    = (state_q == ISSUE && !wr_q) ? op_q : NOP;
  assign mem_waddr = addr_q;
  assign mem_raddr = addr_q;
  assign mem_wdata = wdata_q;

  assign rsp_valid = (state_q != RESP) ? 2'b00 : (own_q ? 2'b10 : 2'b01);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_sparce_mem_arb.sv
module tb_sparce_mem_arb;
  import sparceMemPkg::*;

  localparam int AW = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  op_e  [1:0]            req_op;
  logic [1:0][AW-1:0]    req_addr;
  logic [1:0][7:0][7:0]  req_wdata;
  logic                  rsp_err;
  logic [7:0][7:0]       rsp_rdata;
  logic                  mem_cs;
  op_e                   mem_we, mem_re;
  logic [AW-1:0]         mem_waddr, mem_raddr;
  logic [7:0][7:0]       mem_wdata;
  logic [7:0][7:0]       mem_rdata = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int rr_ptr = 0;

  sparce_mem_arb #(.ADDR_W(AW), .BC(8), .BADDR(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int sz_of(input op_e op);
    case (op)
      BYTE_OP:  return 1;
      HALF_OP:  return 2;
      WORD_OP:  return 4;
      DWORD_OP: return 8;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [7:0] fill(input logic [31:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // memory environment: byte-addressed, registered read of the whole word
  logic [7:0] env_mem [logic [31:0]];
  logic [31:0] env_a;
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we != NOP)
        for (int k = 0; k < sz_of(mem_we); k++)
          env_mem[mem_waddr + 32'(k)] = mem_wdata[int'(mem_waddr[2:0]) + k];
      if (mem_re != NOP)
        for (int k = 0; k < 8; k++) begin
          env_a = {mem_raddr[31:3], 3'b000} + 32'(k);
          mem_rdata[k] <= env_mem.exists(env_a) ? env_mem[env_a] : fill(env_a);
        end
    end
  end

  // reference: byte image of everything legally written so far
  logic [7:0] exp_mem [logic [31:0]];

  function automatic logic [63:0] exp_read(input logic [31:0] addr, input op_e op);
    logic [63:0] r;
    logic [31:0] a;
    int lane;
    r = '0;
    for (int k = 0; k < sz_of(op); k++) begin
      a    = addr + 32'(k);
      lane = int'(addr[2:0]) + k;
      r[lane*8 +: 8] = exp_mem.exists(a) ? exp_mem[a] : fill(a);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_mem_cs"},    mem_cs,    0);
    chk({tag, "_mem_we"},    mem_we,    NOP);
    chk({tag, "_mem_re"},    mem_re,    NOP);
    chk({tag, "_mem_waddr"}, mem_waddr, 0);
    chk({tag, "_mem_raddr"}, mem_raddr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One transaction from requester i with rsp_ready high; starts and ends on a negedge.
  task automatic do_txn(input int i, input logic wr, input op_e op,
                        input logic [31:0] addr, input logic [63:0] wd);
    int sz, lat, cs_cnt, cs_k, rsp_k;
    logic legal, got;
    logic [63:0] exp_rd;
    op_e s_we, s_re;
    logic [31:0] s_wa, s_ra;
    logic [63:0] s_wd;
    sz     = sz_of(op);
    legal  = (sz != 0) ? ((int'(addr[2:0]) % sz) == 0) : 1'b0;
    lat    = !legal ? 1 : (wr ? 2 : 3);
    exp_rd = (legal && !wr) ? exp_read(addr, op) : 64'h0;
    if (legal && wr)
      for (int k = 0; k < sz; k++)
        exp_mem[addr + 32'(k)] = wd[(int'(addr[2:0]) + k)*8 +: 8];
    req_write[i] = wr; req_op[i] = op; req_addr[i] = addr; req_wdata[i] = wd;
    req_valid[i] = 1'b1;
    got = 1'b0;
    for (int b = 0; b < 10 && !got; b++) begin
      #1;
      if (req_ready[i]) got = 1'b1;
      else @(negedge clk);
    end
    chk("accept", got, 1);
    if (!got) begin req_valid[i] = 1'b0; return; end
    chk("ready_onehot", req_ready, 64'(2'b01 << i));
    rr_ptr = 1 - i;
    @(posedge clk); @(negedge clk);
    req_valid[i] = 1'b0;
    cs_cnt = 0; cs_k = -1; rsp_k = -1;
    s_we = NOP; s_re = NOP; s_wa = '0; s_ra = '0; s_wd = '0;
    for (int k = 1; k <= 6; k++) begin
      if (mem_cs) begin
        cs_cnt++;
        if (cs_k < 0) begin
          cs_k = k; s_we = mem_we; s_re = mem_re; s_wa = mem_waddr; s_ra = mem_raddr; s_wd = mem_wdata;
        end
      end
      if (rsp_valid[i]) begin
        rsp_k = k;
        chk("rsp_err", rsp_err, !legal);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_other", rsp_valid[1-i], 0);
        break;
      end
      @(negedge clk);
    end
    chk("rsp_latency", rsp_k, lat);
    chk("cs_count", cs_cnt, legal ? 1 : 0);
    if (legal) begin
      chk("cs_latency", cs_k, 1);
      chk("mem_we", s_we, wr ? op : NOP);
      chk("mem_re", s_re, wr ? NOP : op);
      chk("mem_waddr", s_wa, addr);
      chk("mem_raddr", s_ra, addr);
      chk("mem_wdata", s_wd, wd);
    end
    if (rsp_k > 0) @(negedge clk);
    chk("rsp_done", rsp_valid, 0);
  endtask

  // Both requesters stream two DWORD writes each; grants must follow round-robin.
  task automatic dual(input logic [31:0] a0, input logic [31:0] a1);
    logic [63:0] wd [2][2];
    int idx [2];
    int got, g;
    logic [1:0] exp_g;
    logic [31:0] ba;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++) wd[k][j] = {$urandom(), $urandom()};
    idx[0] = 0; idx[1] = 0; got = 0;
    for (int b = 0; b < 40 && got < 4; b++) begin
      for (int k = 0; k < 2; k++) begin
        if (idx[k] < 2) begin
          req_valid[k] = 1'b1; req_write[k] = 1'b1; req_op[k] = DWORD_OP;
          req_addr[k]  = (k == 0 ? a0 : a1) + 32'(8*idx[k]);
          req_wdata[k] = wd[k][idx[k]];
        end else req_valid[k] = 1'b0;
      end
      #1;
      if (req_ready != 2'b00) begin
        if (req_valid == 2'b11) exp_g = (rr_ptr == 1) ? 2'b10 : 2'b01;
        else                    exp_g = req_valid;
        chk("dual_grant", req_ready, exp_g);
        g  = req_ready[1] ? 1 : 0;
        ba = (g == 0 ? a0 : a1) + 32'(8*idx[g]);
        for (int k = 0; k < 8; k++) exp_mem[ba + 32'(k)] = wd[g][idx[g]][k*8 +: 8];
        rr_ptr = 1 - g;
        idx[g]++;
        got++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("dual_count", got, 4);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 2; j++)
        do_txn(1 - k, 1'b0, DWORD_OP, (k == 0 ? a0 : a1) + 32'(8*j), 64'h0);
  endtask

  task automatic backpressure();
    logic [63:0] exp_rd;
    logic got;
    exp_rd = exp_read(32'h104, WORD_OP);
    rsp_ready[0] = 1'b0;
    req_write[0] = 1'b0; req_op[0] = WORD_OP; req_addr[0] = 32'h104; req_wdata[0] = '0;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int b = 0; b < 10 && !got; b++) begin
      #1;
      if (req_ready[0]) got = 1'b1;
      else @(negedge clk);
    end
    chk("bp_accept", got, 1);
    rr_ptr = 1;
    @(posedge clk); @(negedge clk);
    req_valid[0] = 1'b0;
    got = 1'b0;
    for (int b = 0; b < 6 && !got; b++) begin
      if (rsp_valid[0]) got = 1'b1;
      else @(negedge clk);
    end
    chk("bp_rsp_seen", got, 1);
    req_write[1] = 1'b1; req_op[1] = WORD_OP; req_addr[1] = 32'h120; req_wdata[1] = 64'h1;
    req_valid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", rsp_valid, 2'b01);
      chk("bp_rdata", rsp_rdata, exp_rd);
      chk("bp_err", rsp_err, 0);
      chk("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("bp_release", rsp_valid, 0);
  endtask

  task automatic reset_in_wait_rd();
    logic got;
    req_write[1] = 1'b0; req_op[1] = WORD_OP; req_addr[1] = 32'h108; req_wdata[1] = '0;
    req_valid[1] = 1'b1;
    got = 1'b0;
    for (int b = 0; b < 10 && !got; b++) begin
      #1;
      if (req_ready[1]) got = 1'b1;
      else @(negedge clk);
    end
    chk("rst_accept", got, 1);
    @(posedge clk); @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rst_issue_cs", mem_cs, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;
    chk_idle("rst_wait_rd");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
    end
  endtask

  initial begin
    int i;
    logic wr;
    op_e op;
    int sz;
    logic [31:0] addr;
    rst = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; rsp_ready = 2'b11;
    req_op[0] = NOP; req_op[1] = NOP;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    do_txn(0, 1'b1, WORD_OP, 32'h104, 64'hDDCCBBAA_44332211);
    do_txn(1, 1'b0, WORD_OP, 32'h104, 64'h0);
    chk("readback_word", exp_read(32'h104, WORD_OP), 64'hDDCCBBAA_00000000);
    do_txn(0, 1'b0, HALF_OP, 32'h101, 64'h0);
    do_txn(1, 1'b1, NOP,     32'h100, 64'hFFFF);
    do_txn(0, 1'b1, BYTE_OP, 32'h107, 64'h5500000000000000);
    do_txn(1, 1'b0, DWORD_OP, 32'h100, 64'h0);

    dual(32'h300, 32'h380);

    for (int n = 0; n < 40; n++) begin
      i    = int'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      op   = op_e'(3'($urandom_range(0, 4)));
      sz   = sz_of(op);
      addr = 32'h200 + 32'(8 * $urandom_range(0, 3)) + 32'($urandom_range(0, 7));
      if (sz != 0 && $urandom_range(0, 1) == 1) addr = addr & ~32'(sz - 1);
      do_txn(i, wr, op, addr, {$urandom(), $urandom()});
    end

    backpressure();
    reset_in_wait_rd();
    dual(32'h400, 32'h480);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
